// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshakes
// Optional feature: define CLA_PIPE_SAT_EN to saturate sum to the signed extreme on overflow.
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / GROUP;

`ifdef CLA_PIPE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Per-stage registers: ra/rb carry the not-yet-added upper operand bits (skew),
  // rs accumulates the finished lower sum segments (deskew), rc is the segment carry.
  logic [WIDTH-1:0] ra [STAGES];
  logic [WIDTH-1:0] rb [STAGES];
  logic [WIDTH-1:0] rs [STAGES];
  logic             rc [STAGES];
  logic             rv [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] na [STAGES];
  logic [WIDTH-1:0] nb [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic             nc [STAGES];
  logic             nv [STAGES];
  logic             novf;

  logic advance;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !rst;
  assign out_valid = rv[STAGES-1];
  assign sum       = rs[STAGES-1];
  assign cout      = rc[STAGES-1];
  assign ovf       = ovf_q;

  // Returns {carry out, carry into segment MSB, segment sum}.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    logic [SEG-1:0] g, p, c;
    logic [NG-1:0]  gg, gp;
    logic [NG:0]    gc;
    logic           t;
    g  = x & y;
    p  = x ^ y;
    c  = '0;
    gg = '0;
    gp = '0;
    gc = '0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg[k] = g[k*GROUP+i] | (p[k*GROUP+i] & gg[k]);
        gp[k] = gp[k] & p[k*GROUP+i];
      end
    end
    // Each group carry is a flat sum of products over G/P terms, independent of other group carries.
    for (int k = 0; k <= NG; k++) begin
      gc[k] = ci;
      for (int j = 0; j < k; j++) gc[k] = gc[k] & gp[j];
      for (int j = 0; j < k; j++) begin
        t = gg[j];
        for (int m = j + 1; m < k; m++) t = t & gp[m];
        gc[k] = gc[k] | t;
      end
    end
    for (int k = 0; k < NG; k++) begin
      c[k*GROUP] = gc[k];
      for (int i = 0; i < GROUP - 1; i++)
        c[k*GROUP+i+1] = g[k*GROUP+i] | (p[k*GROUP+i] & c[k*GROUP+i]);
    end
    return {gc[NG], c[SEG-1], p ^ c};
  endfunction

  always_comb begin
    logic [WIDTH-1:0] pa, pb, ps;
    logic             pc, pv;
    logic [SEG+1:0]   res;
    pa   = a;
    pb   = sub ? ~b : b;
    pc   = sub | cin;
    pv   = in_valid;
    ps   = '0;
    res  = '0;
    novf = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      res = cla_seg(pa[s*SEG +: SEG], pb[s*SEG +: SEG], pc);
      ns[s] = ps;
      ns[s][s*SEG +: SEG] = res[SEG-1:0];
      na[s] = pa;
      nb[s] = pb;
      nc[s] = res[SEG+1];
      nv[s] = pv;
      if (s == STAGES - 1) begin
        novf = res[SEG] ^ res[SEG+1];
        // On overflow both operands share a sign, so A's MSB gives the true result sign.
        if (SAT_EN && novf) ns[s] = pa[WIDTH-1] ? SAT_NEG : SAT_POS;
      end
      pa = ra[s];
      pb = rb[s];
      pc = rc[s];
      ps = rs[s];
      pv = rv[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        ra[s] <= '0;
        rb[s] <= '0;
        rs[s] <= '0;
        rc[s] <= 1'b0;
        rv[s] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        ra[s] <= na[s];
        rb[s] <= nb[s];
        rs[s] <= ns[s];
        rc[s] <= nc[s];
        rv[s] <= nv[s];
      end
      ovf_q <= novf;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - scoreboard bench for cla_pipe_addsub (WIDTH=32, STAGES=2, GROUP=4)
module tb_cla_pipe_addsub;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int GROUP  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              cin = 1'b0;
  logic              sub = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;

  cla_pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    logic             lat;
    logic [31:0]      cyc;
  } exp_t;

  exp_t        q[$];
  int          nassert = 0;
  int          nfail = 0;
  int          nout = 0;
  logic [31:0] cyc = 0;
  bit          chk_lat = 1'b1;
  bit          bp_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_sum = '0;
  logic        prev_c = 1'b0;
  logic        prev_o = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                 input logic tc, input logic ts, input logic [31:0] tcyc,
                                 input bit tl);
    exp_t e;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    bb   = ts ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, bb} + {{WIDTH{1'b0}}, (ts ? 1'b1 : tc)};
    e.s  = full[WIDTH-1:0];
    e.c  = full[WIDTH];
    e.o  = (ta[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
`ifdef CLA_PIPE_SAT_EN
    if (e.o) e.s = ta[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    e.lat = tl;
    e.cyc = tcyc;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: output transfers pop the scoreboard, input transfers push the model result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (prev_stall) chk("stall_hold", {30'd0, out_valid, sum, cout, ovf}, {30'd0, 1'b1, prev_sum, prev_c, prev_o});
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_c     = cout;
      prev_o     = ovf;
      if (out_valid && out_ready) begin
        nout++;
        chk("beat_expected", {63'd0, q.size() > 0}, 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sb_sum", {32'd0, sum}, {32'd0, e.s});
          chk("sb_cout", {63'd0, cout}, {63'd0, e.c});
          chk("sb_ovf", {63'd0, ovf}, {63'd0, e.o});
          if (e.lat && chk_lat) chk("sb_latency", {32'd0, cyc - e.cyc}, STAGES);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, cyc, chk_lat));
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                      input logic tc, input logic ts);
    bit ok;
    ok = 1'b0;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_one(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input logic tc, input logic ts,
                           input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    send(ta, tb_, tc, ts);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk({tag, "_edges"}, n, STAGES);
    chk({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
    chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({tag, "_drain"}, q.size(), 0);
  endtask

  initial begin
    int n0;
    logic [31:0] c0;
    logic [WIDTH-1:0] sat_p, sat_n, wr_p, wr_n;

    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    chk("rst_in_ready", {63'd0, in_ready}, 0);
    chk("rst_sum", {32'd0, sum}, 0);
    chk("rst_flags", {62'd0, cout, ovf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 1);

    check_one("carry_xseg", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    check_one("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check_one("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    check_one("sub_cin_ignored", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
    check_one("add_cin_wrap", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
`ifdef CLA_PIPE_SAT_EN
    sat_p = 32'h7FFF_FFFF; sat_n = 32'h8000_0000;
`else
    sat_p = 32'h8000_0000; sat_n = 32'h7FFF_FFFF;
`endif
    wr_p = sat_p; wr_n = sat_n;
    check_one("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, wr_p, 1'b0, 1'b1);
    check_one("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, wr_n, 1'b1, 1'b1);
    drain("directed");

    chk_lat = 1'b0;
    n0 = nout;
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 40; i++) @(posedge clk);
    bp_en = 1'b0;
    #2;
    out_ready = 1'b1;
    drain("backpressure");
    chk("bp_count", nout - n0, 8);
    chk_lat = 1'b1;

    n0 = nout;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("fullrate_cycles", {32'd0, cyc - c0}, 100);
    drain("fullrate");
    chk("fullrate_count", nout - n0, 100);

    out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 0);
    chk("midrst_in_ready", {63'd0, in_ready}, 0);
    q.delete();
    @(posedge clk); @(posedge clk); #1;
    chk("midrst_sum", {32'd0, sum}, 0);
    chk("midrst_flags", {62'd0, cout, ovf}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    n0 = nout;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst_no_stale", nout - n0, 0);
    check_one("after_rst", 32'h1234_5678, 32'h0000_0008, 1'b0, 1'b0, 32'h1234_5680, 1'b0, 1'b0);
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
